// File: rtl/fios_mm_pkg.sv
// Shared types and helpers for the word-serial FIOS Montgomery multiplier.
// Optional final subtraction is selected by the FIOS_MM_FINAL_SUB_EN macro.
package fios_mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_FIN  = 3'd2,
    ST_SUB  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Width of a counter that must reach the value s inclusive.
  function automatic int cnt_w(input int s);
    return (s < 1) ? 1 : $clog2(s + 1);
  endfunction

  // Cycles from the accept edge to done_o high.
  function automatic int lat_cycles(input int s, input bit sub_en);
    return s * (s + 1) + (sub_en ? s : 0) + 1;
  endfunction

  localparam int LAT_S8_SUB   = 81;
  localparam int LAT_S8_NOSUB = 73;

endpackage

// File: rtl/fios_mm_serial_pe.sv
// Combinational FIOS word step: t + a*b + m*p + c, split into a low word
// and a W+2 bit carry. Used for every j, including j = 0 (c is zero then).
module fios_word_pe
  import fios_mm_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] t,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  input  logic [W-1:0] p,
  input  logic [W+1:0] c,
  output logic [W-1:0] sum_lo,
  output logic [W+1:0] c_out
);

  logic [2*W+1:0] sum;

  // Full-width word step; 2W+2 bits cannot overflow for these operand sizes.
  always_comb begin
    sum    = {{(W+2){1'b0}}, t}
           + ({{(W+2){1'b0}}, a} * {{(W+2){1'b0}}, b})
           + ({{(W+2){1'b0}}, m} * {{(W+2){1'b0}}, p})
           + {{W{1'b0}}, c};
    sum_lo = sum[W-1:0];
    c_out  = sum[2*W+1:W];
  end

endmodule

// File: rtl/fios_mm_serial.sv
// Word-serial FIOS Montgomery multiplier: res_o = a*b*2^(-S*W) mod p.
// One word-step per cycle, one carry-fold cycle per outer word of b.
// FIOS_MM_FINAL_SUB_EN adds an S-cycle conditional subtraction so that
// res_o < p; without it res_o < 2p.
module fios_mm_serial
  import fios_mm_pkg::*;
#(
  parameter int W = 17,
  parameter int S = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [W-1:0]     p_prime_0_i,
  input  logic [S*W-1:0]   a_i,
  input  logic [S*W-1:0]   b_i,
  input  logic [S*W-1:0]   p_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [S*W-1:0]   res_o
);

  localparam int N  = S * W;
  localparam int CW = cnt_w(S);

  state_t         state_q;
  logic [N-1:0]   a_q, b_q, p_q, res_q;
  logic [W-1:0]   pp0_q, m_q;
  logic [W-1:0]   t_q [0:S];
  logic [W+1:0]   c_q;
  logic [CW-1:0]  i_q, j_q;

  logic [W-1:0]   a_word, b_word, p_word, t_word;
  logic [W-1:0]   m_calc, m_use, pe_lo;
  logic [W+1:0]   pe_c;
  logic [2*W-1:0] fin_sum;
  logic [N-1:0]   t_fin_vec;
  logic           last_i, last_j;

`ifdef FIOS_MM_FINAL_SUB_EN
  logic [N-1:0]   d_q;
  logic           borrow_q;
  logic [W:0]     diff;
  logic [N-1:0]   d_fin_vec, t_vec;
  logic           sel_d;
`endif

  // Operand word selection, m for the current outer step and the FIN fold.
  // m is needed in the same cycle it is derived (j = 0), so the PE takes the
  // freshly computed value then and the registered copy for j > 0.
  always_comb begin
    a_word = a_q[j_q*W +: W];
    p_word = p_q[j_q*W +: W];
    t_word = t_q[j_q];
    b_word = '0;
    if (i_q < CW'(S)) b_word = b_q[i_q*W +: W];
    m_calc  = (t_q[0] + a_q[W-1:0] * b_word) * pp0_q;
    m_use   = (j_q == '0) ? m_calc : m_q;
    fin_sum = {{W{1'b0}}, t_q[S]} + {{(W-2){1'b0}}, c_q};
    last_i  = (i_q == CW'(S - 1));
    last_j  = (j_q == CW'(S - 1));
    for (int unsigned k = 0; k < S; k++)
      t_fin_vec[k*W +: W] = (k == S - 1) ? fin_sum[W-1:0] : t_q[k];
  end

`ifdef FIOS_MM_FINAL_SUB_EN
  // Borrow-chained subtraction word and final result selection.
  always_comb begin
    diff = {1'b0, t_word} - {1'b0, p_word} - {{W{1'b0}}, borrow_q};
    for (int unsigned k = 0; k < S; k++) begin
      t_vec[k*W +: W]     = t_q[k];
      d_fin_vec[k*W +: W] = (k == S - 1) ? diff[W-1:0] : d_q[k*W +: W];
    end
    sel_d = (t_q[S] != '0) || !diff[W];
  end
`endif

  fios_word_pe #(.W(W)) u_pe (
    .t      (t_word),
    .a      (a_word),
    .b      (b_word),
    .m      (m_use),
    .p      (p_word),
    .c      (c_q),
    .sum_lo (pe_lo),
    .c_out  (pe_c)
  );

  // Control FSM with counters, T/D storage and output register.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      pp0_q   <= '0;
      res_q   <= '0;
      m_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      for (int unsigned k = 0; k <= S; k++) t_q[k] <= '0;
`ifdef FIOS_MM_FINAL_SUB_EN
      d_q      <= '0;
      borrow_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            p_q   <= p_i;
            pp0_q <= p_prime_0_i;
            m_q   <= '0;
            c_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            for (int unsigned k = 0; k <= S; k++) t_q[k] <= '0;
`ifdef FIOS_MM_FINAL_SUB_EN
            borrow_q <= 1'b0;
`endif
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          c_q <= pe_c;
          if (j_q == '0) m_q <= m_calc;
          else           t_q[j_q - CW'(1)] <= pe_lo;
          if (last_j) state_q <= ST_FIN;
          else        j_q <= j_q + CW'(1);
        end
        ST_FIN: begin
          t_q[S]   <= fin_sum[2*W-1:W];
          t_q[S-1] <= fin_sum[W-1:0];
          c_q      <= '0;
          j_q      <= '0;
          i_q      <= i_q + CW'(1);
          if (last_i) begin
`ifdef FIOS_MM_FINAL_SUB_EN
            state_q <= ST_SUB;
`else
            // Result is loaded on entry to DONE so it is valid with done_o.
            res_q   <= t_fin_vec;
            state_q <= ST_DONE;
`endif
          end else begin
            state_q <= ST_MUL;
          end
        end
`ifdef FIOS_MM_FINAL_SUB_EN
        ST_SUB: begin
          d_q[j_q*W +: W] <= diff[W-1:0];
          borrow_q        <= diff[W];
          if (last_j) begin
            res_q   <= sel_d ? d_fin_vec : t_vec;
            j_q     <= '0;
            state_q <= ST_DONE;
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign res_o   = res_q;

endmodule

// File: tb/tb_fios_mm_serial.sv
// Scoreboard bench for fios_mm_serial (W=17, S=2). Expected results come
// from the closed-form Montgomery product T = (a*b + M*p) / R, with
// M = -a*b*p^-1 mod R, optionally reduced once by p (FIOS_MM_FINAL_SUB_EN).
module tb_fios_mm_serial;
  import fios_mm_pkg::*;

  localparam int W = 17;
  localparam int S = 2;
  localparam int N = S * W;
`ifdef FIOS_MM_FINAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  localparam int LAT = lat_cycles(S, SUB_EN);
  localparam logic [63:0] P0 = 64'h1_0000_0001;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] pp0;
  logic [N-1:0] a_in, b_in, p_in;
  logic         ready, done;
  logic [N-1:0] res;

  typedef struct {
    logic [N-1:0] res;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic         rst_prev = 1'b0;
  logic         done_prev = 1'b0;
  logic [N-1:0] last_res = '0;

  fios_mm_serial #(.W(W), .S(S)) dut (
    .clock_i     (clk),
    .reset_n_i   (reset_n),
    .start_i     (start),
    .p_prime_0_i (pp0),
    .a_i         (a_in),
    .b_i         (b_in),
    .p_i         (p_in),
    .ready_o     (ready),
    .done_o      (done),
    .res_o       (res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= reset_n;
  end

  // -p^-1 mod 2^64 by Newton iteration (p odd).
  function automatic logic [63:0] neg_inv(input logic [63:0] p);
    logic [63:0] x;
    x = p;
    for (int k = 0; k < 6; k++) x = x * (64'd2 - p * x);
    return ~x + 64'd1;
  endfunction

  function automatic logic [N-1:0] mont(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] p, input bit sub);
    logic [135:0] ab, mm, t, rmask;
    rmask = (136'd1 << N) - 136'd1;
    ab = 136'(a) * 136'(b);
    mm = ((ab & rmask) * 136'(neg_inv(p))) & rmask;
    t  = (ab + mm * 136'(p)) >> N;
    if (sub && t >= 136'(p)) t = t - 136'(p);
    return t[N-1:0];
  endfunction

  // Monitor: pops the scoreboard whenever done_o is presented.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_vec++;
      if (done_prev) begin
        n_err++;
        $display("FAIL done_width: done_o high two cycles in a row at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done_o at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (res !== e.res) begin
          n_err++;
          $display("FAIL result: got %h want %h", res, e.res);
        end
        n_vec++;
        if (cyc - e.acc != LAT) begin
          n_err++;
          $display("FAIL latency: got %0d want %0d", cyc - e.acc, LAT);
        end
      end
    end else if (rst_prev && res !== last_res) begin
      n_err++;
      $display("FAIL res_hold: res_o changed to %h from %h outside DONE", res, last_res);
    end
    last_res  = res;
    done_prev = done;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] p,
                       input bit push);
    logic [63:0] ni;
    int g;
    g = 0;
    @(negedge clk);
    while (!ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: ready_o low for %0d cycles", g);
    end
    ni    = neg_inv(p);
    a_in  = a[N-1:0];
    b_in  = b[N-1:0];
    p_in  = p[N-1:0];
    pp0   = ni[W-1:0];
    start = 1'b1;
    if (push) exp_q.push_back('{res: mont(a, b, p, SUB_EN), acc: cyc});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !ready) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0 || !ready) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: %0d results outstanding, ready_o %b", exp_q.size(), ready);
    end
    @(negedge clk);
  endtask

  task automatic check_mod(input string name, input logic [63:0] want);
    logic [63:0] r;
    r = 64'(res);
    check(name, r % P0, want);
    check({name, "_range"}, 64'(r < (SUB_EN ? P0 : 2 * P0)), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p, a, b;
    int          acc_prev;
    int          g;

    reset_n = 1'b0;
    start   = 1'b0;
    pp0     = '0;
    a_in    = '0;
    b_in    = '0;
    p_in    = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_res", 64'(res), 64'd0);

    // Directed: R mod p times b, R^2 mod p times 5, zero operand.
    issue(64'hFFFF_FFFD, 64'h12345, P0, 1'b1);
    wait_idle();
    check_mod("dir_rmodp", 64'h12345);
    issue(64'd16, 64'd5, P0, 1'b1);
    wait_idle();
    check_mod("dir_r2", 64'hFFFF_FFED);
    issue(64'd0, 64'h1_2345_6789, P0, 1'b1);
    wait_idle();
    check("dir_zero", 64'(res), 64'd0);

    // start_i held high: accepts only in IDLE, spaced LAT+1 apart.
    a_in     = 34'h0_1234_5678;
    b_in     = 34'h0_9ABC_DEF0;
    p_in     = P0[N-1:0];
    pp0      = 17'h1FFFF;
    acc_prev = 0;
    for (int k = 0; k < 3; k++) begin
      g = 0;
      @(negedge clk);
      while (!ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      start = 1'b1;
      exp_q.push_back('{res: mont(64'(a_in), 64'(b_in), P0, SUB_EN), acc: cyc});
      if (k > 0) check("hold_period", 64'(cyc - acc_prev), 64'(LAT + 1));
      acc_prev = cyc;
      @(posedge clk);
    end
    #1 start = 1'b0;
    wait_idle();

    // Reset in cycle 4 of an operation aborts it with no output.
    issue(64'h1_0000_0000, 64'h0_FFFF_0001, P0, 1'b0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_res", 64'(res), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (LAT + 3) @(negedge clk);
    issue(64'h1_0000_0000, 64'h0_FFFF_0001, P0, 1'b1);
    wait_idle();

    // Randomised moduli and operands, back to back.
    for (int k = 0; k < 24; k++) begin
      p = {30'd0, 2'b01, $urandom} | 64'd1;
      a = {$urandom, $urandom} % p;
      b = {$urandom, $urandom} % p;
      if (k % 8 == 0) a = p - 64'd1;
      issue(a, b, p, 1'b1);
    end
    wait_idle();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
